// File: rtl/memory_module_pkg.sv
// Shared constants for the memory block: control-word bit positions,
// default widths and the loader state encoding.
package memory_module_pkg;

    localparam int CONTROL_SIGNALS = 16;
    localparam int ADDR_WIDTH      = 8;
    localparam int DATA_WIDTH      = 8;

    // Control-word bit positions driven by the control unit
    localparam int MAI = 14;   // load MAR from bus
    localparam int MI  = 13;   // write bus into RAM at MAR
    localparam int MO  = 12;   // drive RAM at MAR onto bus

    // Program-loader states
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/ram_array.sv
// Single-port register file: synchronous write, asynchronous read at the
// same address. No reset, contents survive rst.
module ram_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    // Store the write data at the addressed word
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_module.sv
// RAM + MAR for the CPU bus, plus a byte-stream program loader that fills
// RAM from address 0 while holding the CPU.
//
//   state   | meaning
//   LD_IDLE | CPU owns MAR/RAM via MAI/MI/MO
//   LD_LOAD | loader accepts bytes into RAM[pointer], CPU held, ctrl ignored
//   LD_DONE | one-cycle completion pulse, CPU still held, MAR cleared on exit
module memory_module
    import memory_module_pkg::*;
#(
    parameter int CONTROL_SIGNALS = memory_module_pkg::CONTROL_SIGNALS,
    parameter int ADDR_WIDTH      = memory_module_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = memory_module_pkg::DATA_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [CONTROL_SIGNALS-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0]      i_bus_in,
    output logic [DATA_WIDTH-1:0]      o_bus_out,
    output logic                       o_bus_oe,
    output logic [ADDR_WIDTH-1:0]      o_mar,
    input  logic                       i_load_start,
    input  logic                       i_load_valid,
    input  logic [DATA_WIDTH-1:0]      i_load_data,
    input  logic                       i_load_last,
    output logic                       o_load_ready,
    output logic                       o_cpu_hold,
    output logic                       o_load_done,
    output logic                       o_load_overflow
);

    ld_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_mar;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_ready;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_ovf;

    logic                  w_idle;
    logic                  w_loading;
    logic                  w_mai;
    logic                  w_mi;
    logic                  w_mo;
    logic                  w_accept;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_ctrl;

    // CPU control bits only take effect in IDLE and out of reset
    assign w_idle    = (r_state == LD_IDLE);
    assign w_loading = (r_state == LD_LOAD);
    assign w_mai     = i_rst & w_idle & i_ctrl[MAI];
    assign w_mi      = i_rst & w_idle & i_ctrl[MI];
    assign w_mo      = i_rst & w_idle & i_ctrl[MO];
    assign w_accept  = i_rst & r_ready & i_load_valid;

    // Only the three memory bits are consumed from the control word
    assign w_unused_ctrl = ^i_ctrl;

    // The single RAM port is shared: loader pointer in LOAD, MAR otherwise
    assign w_we    = w_mi | w_accept;
    assign w_addr  = w_loading ? r_ptr : r_mar;
    assign w_wdata = w_loading ? i_load_data : i_bus_in;

    ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign o_bus_out       = w_rdata;
    assign o_bus_oe        = w_mo;
    assign o_mar           = r_mar;
    assign o_load_ready    = r_ready;
    assign o_cpu_hold      = r_hold;
    assign o_load_done     = r_done;
    assign o_load_overflow = r_ovf;

    // MAR: loaded from the bus on MAI (also the indirect-fetch path when MO
    // drives the bus), cleared when a load finishes so the CPU restarts at 0
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mar <= '0;
        end else if (r_state == LD_DONE) begin
            r_mar <= '0;
        end else if (w_mai) begin
            r_mar <= i_bus_in[ADDR_WIDTH-1:0];
        end
    end

    // Loader FSM with registered ready/hold/done/overflow outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= LD_IDLE;
            r_ptr   <= '0;
            r_ready <= 1'b0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                LD_IDLE: begin
                    if (i_load_start) begin
                        r_state <= LD_LOAD;
                        r_ptr   <= '0;
                        r_ready <= 1'b1;
                        r_hold  <= 1'b1;
                        r_ovf   <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (w_accept) begin
                        if (i_load_last) begin
                            r_state <= LD_DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_ptr == {ADDR_WIDTH{1'b1}}) begin
                            // Last slot filled without load_last: stop, never wrap
                            r_state <= LD_DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                            r_ovf   <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                LD_DONE: begin
                    r_state <= LD_IDLE;
                    r_done  <= 1'b0;
                    r_hold  <= 1'b0;
                end
                default: begin
                    r_state <= LD_IDLE;
                    r_ready <= 1'b0;
                    r_hold  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Writing and reading RAM in the same cycle is not a legal microcode step
    a_no_mi_mo: assert property (@(posedge i_clk) disable iff (!i_rst) !(w_mi && w_mo));

endmodule

// File: tb/tb_memory_module.sv
// Self-checking bench for memory_module: directed table, loader sequences,
// then random traffic against a behavioural model.
module tb_memory_module;
    import memory_module_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ctrl = '0;
    logic [7:0]  bus_in = '0;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [7:0]  mar;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        cpu_hold;
    logic        load_done;
    logic        load_overflow;

    memory_module dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ctrl          (ctrl),
        .i_bus_in        (bus_in),
        .o_bus_out       (bus_out),
        .o_bus_oe        (bus_oe),
        .o_mar           (mar),
        .i_load_start    (load_start),
        .i_load_valid    (load_valid),
        .i_load_data     (load_data),
        .i_load_last     (load_last),
        .o_load_ready    (load_ready),
        .o_cpu_hold      (cpu_hold),
        .o_load_done     (load_done),
        .o_load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] C_MAI = 16'h1 << MAI;
    localparam logic [15:0] C_MI  = 16'h1 << MI;
    localparam logic [15:0] C_MO  = 16'h1 << MO;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: phase 0 = CPU owns memory, 1 = loading, 2 = done pulse
    int         m_phase = 0;
    logic [7:0] m_mar = '0;
    int         m_ptr = 0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_mem [256];
    bit         m_known [256];

    typedef struct {
        logic [15:0] ctrl;
        logic [7:0]  bus;
        logic [7:0]  exp_mar;
        logic        exp_oe;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_mar   = '0;
        m_ptr   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] old_mar;
        if (!rst) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                old_mar = m_mar;
                if (ctrl[MAI]) m_mar = bus_in;
                if (ctrl[MI]) begin
                    m_mem[old_mar]   = bus_in;
                    m_known[old_mar] = 1'b1;
                end
                if (load_start) begin
                    m_phase = 1;
                    m_ptr   = 0;
                    m_ovf   = 1'b0;
                end
            end
            1: begin
                if (load_valid) begin
                    m_mem[m_ptr]   = load_data;
                    m_known[m_ptr] = 1'b1;
                    if (load_last) m_phase = 2;
                    else if (m_ptr == 255) begin
                        m_ovf   = 1'b1;
                        m_phase = 2;
                    end else m_ptr++;
                end
            end
            default: begin
                m_phase = 0;
                m_mar   = '0;
            end
        endcase
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic tick();
        logic exp_oe;
        #1;
        exp_oe = rst && (m_phase == 0) && ctrl[MO];
        chk("mar", mar, m_mar);
        chk("bus_oe", bus_oe, exp_oe);
        chk("load_ready", load_ready, m_phase == 1);
        chk("cpu_hold", cpu_hold, m_phase != 0);
        chk("load_done", load_done, m_phase == 2);
        chk("load_overflow", load_overflow, m_ovf);
        if (exp_oe && m_known[m_mar]) chk("bus_out", bus_out, m_mem[m_mar]);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ctrl = '0; bus_in = '0; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    endtask

    // CPU read of one address through MAI then MO, with an explicit value check
    task automatic cpu_read(input logic [7:0] addr, input logic [7:0] exp, input string name);
        idle_inputs();
        ctrl = C_MAI; bus_in = addr;
        tick();
        ctrl = C_MO; bus_in = '0;
        #1;
        chk(name, {bus_oe, bus_out}, {1'b1, exp});
        tick();
        idle_inputs();
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] val);
        idle_inputs();
        ctrl = C_MAI; bus_in = addr;
        tick();
        ctrl = C_MI; bus_in = val;
        tick();
        idle_inputs();
    endtask

    function automatic logic [15:0] rand_ctrl();
        logic [15:0] c;
        c = 16'($urandom);
        if (c[MI] && c[MO]) c[MI] = 1'b0;
        return c;
    endfunction

    initial begin : main
        logic [7:0] first_byte;
        logic [7:0] last_byte;
        logic [7:0] bp_bytes [4];

        for (int i = 0; i < 256; i++) begin
            m_mem[i] = '0;
            m_known[i] = 1'b0;
        end

        // Directed CPU vectors: inputs, expected pre-edge mar/oe/out
        vecs[0] = '{C_MAI,        8'h0E, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{C_MI,         8'h5A, 8'h0E, 1'b0, 8'h00};
        vecs[2] = '{C_MO,         8'h00, 8'h0E, 1'b1, 8'h5A};
        vecs[3] = '{C_MI,         8'h20, 8'h0E, 1'b0, 8'h00};
        vecs[4] = '{C_MO | C_MAI, 8'h20, 8'h0E, 1'b1, 8'h20};
        vecs[5] = '{16'h0000,     8'hC3, 8'h20, 1'b0, 8'h00};
        vecs[6] = '{C_MI | C_MAI, 8'h33, 8'h20, 1'b0, 8'h00};
        vecs[7] = '{C_MAI,        8'h20, 8'h33, 1'b0, 8'h00};
        vecs[8] = '{C_MO,         8'h00, 8'h20, 1'b1, 8'h33};

        // Reset held with activity on the inputs
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ctrl = rand_ctrl() | C_MAI; bus_in = 8'($urandom);
            load_start = i[0];
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();

        // Directed CPU path
        for (int i = 0; i < 9; i++) begin
            ctrl = vecs[i].ctrl; bus_in = vecs[i].bus;
            #1;
            chk("vec_mar", mar, vecs[i].exp_mar);
            chk("vec_oe", bus_oe, vecs[i].exp_oe);
            if (vecs[i].exp_oe) chk("vec_out", bus_out, vecs[i].exp_out);
            tick();
        end
        idle_inputs();
        tick();
        chk("mar_after_indirect_seq", mar, 8'h20);

        // Basic load of three bytes
        cpu_write(8'h09, 8'hE7);
        load_start = 1; tick(); load_start = 0;
        load_valid = 1;
        load_data = 8'h11; tick();
        load_data = 8'h22; tick();
        load_data = 8'h33; load_last = 1; tick();
        idle_inputs();
        #1;
        chk("done_pulse", {load_done, cpu_hold, load_ready}, 3'b110);
        tick();
        #1;
        chk("hold_released", {load_done, cpu_hold, mar}, {1'b0, 1'b0, 8'h00});
        tick();
        cpu_read(8'h00, 8'h11, "load_mem0");
        cpu_read(8'h01, 8'h22, "load_mem1");
        cpu_read(8'h02, 8'h33, "load_mem2");

        // Backpressure with hostile ctrl on the bus
        cpu_write(8'hFF, 8'h5C);
        load_start = 1; tick(); load_start = 0;
        for (int b = 0; b < 4; b++) begin
            bp_bytes[b] = 8'($urandom);
            for (int g = 0; g < 3; g++) begin
                ctrl = C_MI | C_MAI; bus_in = 8'hFF; load_valid = 0;
                tick();
            end
            ctrl = C_MI | C_MAI; bus_in = 8'hFF;
            load_valid = 1; load_data = bp_bytes[b]; load_last = (b == 3);
            tick();
        end
        idle_inputs();
        tick(); tick();
        for (int b = 0; b < 4; b++) cpu_read(8'(b), bp_bytes[b], "bp_mem");
        cpu_read(8'hFF, 8'h5C, "bp_ff_untouched");

        // Overflow: 257 bytes without load_last
        load_start = 1; tick(); load_start = 0;
        first_byte = 8'($urandom);
        last_byte  = '0;
        load_valid = 1;
        for (int i = 0; i < 256; i++) begin
            load_data = (i == 0) ? first_byte : 8'($urandom);
            last_byte = load_data;
            tick();
        end
        load_data = ~first_byte;
        #1;
        chk("ovf_state", {load_overflow, load_done, load_ready}, 3'b110);
        tick();
        idle_inputs();
        #1;
        chk("ovf_sticky", {load_overflow, cpu_hold}, 2'b10);
        tick();
        cpu_read(8'h00, first_byte, "ovf_mem0_kept");
        cpu_read(8'hFF, last_byte, "ovf_mem255");

        // Reset in the middle of a load
        load_start = 1; tick(); load_start = 0;
        load_valid = 1;
        load_data = 8'hA1; tick();
        load_data = 8'hB2; tick();
        load_data = 8'hC3;
        #2;
        rst = 1'b0;
        load_valid = 0;
        #1;
        chk("async_rst", {cpu_hold, load_ready, load_done, mar}, 11'h0);
        model_reset();
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        cpu_read(8'h00, 8'hA1, "rst_mem0");
        cpu_read(8'h01, 8'hB2, "rst_mem1");
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_data = 8'h4D; load_last = 1; tick();
        idle_inputs();
        tick(); tick();
        cpu_read(8'h00, 8'h4D, "restart_mem0");
        cpu_read(8'h01, 8'hB2, "restart_mem1");

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            ctrl = rand_ctrl();
            bus_in = (ctrl[MO] && m_known[m_mar] && $urandom_range(1)) ? m_mem[m_mar] : 8'($urandom);
            load_start = ($urandom_range(19) == 0);
            load_valid = $urandom_range(1) == 1;
            load_last  = ($urandom_range(7) == 0);
            load_data  = 8'($urandom);
            tick();
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
